// File: rtl/pipe_skid_reg.sv
// Pipeline register with a one-entry skid buffer.
// The main register drives the output; the skid register catches the one
// extra beat that arrives while downstream stalls. Because of the skid
// register, in_ready_o and out_valid_o can both be registered, so there is no
// combinational path from out_ready_i or in_valid_i to either of them.
module pipe_skid_reg #(
  parameter int                 DATA_W       = 110,
  parameter bit                 CLR_ON_FLUSH = 1'b1,
  parameter logic [DATA_W-1:0]  RST_VAL      = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              in_valid_i,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              in_ready_o,
  output logic              out_valid_o,
  output logic [DATA_W-1:0] out_data_o,
  input  logic              out_ready_i,
  output logic [1:0]        count_o
);

  // The encoding doubles as the number of held entries.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t            state_reg, state_next;
  logic [DATA_W-1:0] main_reg, main_next;
  logic [DATA_W-1:0] skid_reg, skid_next;
  logic              in_ready_reg, in_ready_next;
  logic              out_valid_reg, out_valid_next;
  logic [1:0]        count_reg, count_next;
  logic              in_fire;
  logic              out_fire;

  assign in_fire  = in_valid_i & in_ready_reg & ~flush_i;
  assign out_fire = out_valid_reg & out_ready_i;

  // Next-state, payload steering and next values of the registered flags.
  always_comb begin
    state_next = state_reg;
    main_next  = main_reg;
    skid_next  = skid_reg;
    if (flush_i) begin
      // Flush wins over every handshake; an out_fire this cycle still counts
      // as delivered, an offered input is simply dropped.
      state_next = EMPTY;
      if (CLR_ON_FLUSH) begin
        main_next = '0;
        skid_next = '0;
      end
    end else begin
      unique case (state_reg)
        EMPTY: begin
          if (in_fire) begin
            main_next  = in_data_i;
            state_next = BUSY;
          end
        end
        BUSY: begin
          if (in_fire && out_fire) begin
            main_next = in_data_i;
          end else if (in_fire) begin
            // Downstream stalled: park the new beat, keep main stable.
            skid_next  = in_data_i;
            state_next = FULL;
          end else if (out_fire) begin
            state_next = EMPTY;
          end
        end
        FULL: begin
          if (out_fire) begin
            main_next  = skid_reg;
            state_next = BUSY;
          end
        end
        default: begin
          state_next = EMPTY;
        end
      endcase
    end
    in_ready_next  = (state_next != FULL);
    out_valid_next = (state_next != EMPTY);
    count_next     = state_next;
  end

  // State, payload and handshake flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= EMPTY;
      main_reg      <= RST_VAL;
      skid_reg      <= RST_VAL;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      count_reg     <= 2'd0;
    end else begin
      state_reg     <= state_next;
      main_reg      <= main_next;
      skid_reg      <= skid_next;
      in_ready_reg  <= in_ready_next;
      out_valid_reg <= out_valid_next;
      count_reg     <= count_next;
    end
  end

  assign in_ready_o  = in_ready_reg;
  assign out_valid_o = out_valid_reg;
  assign out_data_o  = main_reg;
  assign count_o     = count_reg;

endmodule

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
Parameters:
REQ-001 The block SHALL have parameter DATA_W, default 110, giving the payload width in bits (packs wreg, wreg_addr, wreg_data, aluop, memaddr and operand2 for the EX->MEM boundary).
REQ-002 The block SHALL have parameter CLR_ON_FLUSH, default 1: 1 = zero all payload registers on flush, 0 = clear only the valid state.
REQ-003 The block SHALL have parameter RST_VAL, default all-zero DATA_W-bit constant, giving the payload value loaded at reset.
Ports:
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-006 The block SHALL have port flush_i, input, 1 bit: discard all held and incoming entries.
REQ-007 The block SHALL have port in_valid_i, input, 1 bit: upstream payload valid.
REQ-008 The block SHALL have port in_data_i, input, DATA_W bits: upstream payload.
REQ-009 The block SHALL have port in_ready_o, output, 1 bit: block can accept, driven from a register.
REQ-010 The block SHALL have port out_valid_o, output, 1 bit: downstream payload valid, driven from a register.
REQ-011 The block SHALL have port out_data_o, output, DATA_W bits: downstream payload, driven from the main register.
REQ-012 The block SHALL have port out_ready_i, input, 1 bit: downstream accepts.
REQ-013 The block SHALL have port count_o, output, 2 bits: number of held entries (0..2).

Function
REQ-014 The block SHALL define in_fire = in_valid_i & in_ready_o & !flush_i and out_fire = out_valid_o & out_ready_i.
REQ-015 The block SHALL hold payload in a main register and one skid register and SHALL implement three states: EMPTY (count 0), BUSY (main valid, count 1), FULL (main and skid valid, count 2).
REQ-016 In EMPTY the block SHALL have in_ready_o=1 and out_valid_o=0, and in_fire SHALL load main and move to BUSY.
REQ-017 In BUSY with in_fire and out_fire the block SHALL load main with in_data_i and stay in BUSY, sustaining 1 transfer per cycle.
REQ-018 In BUSY with in_fire and !out_ready_i the block SHALL load skid with in_data_i, leave main unchanged, and move to FULL with in_ready_o=0 in the next cycle.
REQ-019 In BUSY with !in_fire and out_fire the block SHALL move to EMPTY; in BUSY with neither event it SHALL hold main unchanged.
REQ-020 In FULL the block SHALL have in_ready_o=0; out_fire SHALL copy skid into main and move to BUSY, otherwise all state SHALL be held.
REQ-021 The block SHALL have a latency of exactly 1 cycle: data accepted at edge N SHALL appear on out_data_o with out_valid_o=1 after edge N.
REQ-022 The block SHALL present payload to the output in strict acceptance order, with no loss or duplication.
REQ-023 out_data_o SHALL remain stable while out_valid_o=1 and out_ready_i=0.
REQ-024 When flush_i=1 the block SHALL take priority over all other events: next state EMPTY, out_valid_o=0, in_ready_o=1, count_o=0, and main and skid cleared to zero when CLR_ON_FLUSH=1.
REQ-025 An input offered in the flush cycle SHALL be dropped, and an out_fire in the flush cycle SHALL still count as delivered downstream.
REQ-026 count_o SHALL equal 0/1/2 for EMPTY/BUSY/FULL, registered, and SHALL never read 3.
REQ-027 in_ready_o and out_valid_o SHALL depend only on state registers, with no combinational path from out_ready_i or in_valid_i.

Reset
REQ-028 When rst=1 at a rising clk edge the block SHALL enter EMPTY and set out_valid_o=0, in_ready_o=1, count_o=0, and main and skid = RST_VAL.
REQ-029 rst SHALL override flush_i and all handshake inputs, and an entry held mid-operation SHALL be discarded.
REQ-030 The block SHALL change no output asynchronously.

Verification
REQ-031 Streaming: in_valid=1 with data 0x1,0x2,0x3 on consecutive cycles and out_ready=1 -> out_data 0x1,0x2,0x3 one cycle later each, count_o=1 throughout, in_ready_o=1.
REQ-032 Backpressure: hold main=0xA, set out_ready=0, offer 0xB -> count_o=2, in_ready_o=0; on release out_data shows 0xA, then 0xB, with no loss.
REQ-033 Flush in FULL with in_valid=1 carrying 0xC -> next cycle out_valid_o=0, count_o=0, out_data_o=0 (CLR_ON_FLUSH=1), and 0xC never appears.
REQ-034 Flush with CLR_ON_FLUSH=0 -> out_valid_o=0 while out_data_o retains its prior value.
REQ-035 rst=1 asserted in FULL together with flush_i=1 -> next cycle count_o=0, in_ready_o=1, payload = RST_VAL.
REQ-036 Random valid/ready at 50% for 10k cycles -> scoreboard shows in-order, lossless delivery, count_o never 3, and out_data_o stable whenever stalled.
